idct4_stage: RTL

Pipelined 1-D 4-point inverse integer DCT stage: consumes the four padded 13-bit coefficients produced by treatment_inv and emits four rounded, clipped 16-bit residual samples. It uses a two-register pipeline with valid/ready handshakes on both sides, so it can stall under downstream back-pressure. A 4-row block counter flags the last row of each 4×4 block for the transpose stage downstream.

---
 rtl/idct_pkg.sv | 16 +
 rtl/idct4_stage_round_clip.sv | 32 +++
 rtl/idct4_stage.sv | 89 ++++++++
 3 files changed

// File: rtl/idct_pkg.sv
// Shared constants and types for the 4-point inverse integer DCT stage.
package idct_pkg;

  localparam int unsigned COEF_W = 13;
  localparam int unsigned ACC_W  = 22;
  localparam int unsigned OUT_W  = 16;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [OUT_W-1:0]  sample_t;

  localparam acc_t C64 = 22'sd64;
  localparam acc_t C83 = 22'sd83;
  localparam acc_t C36 = 22'sd36;

endpackage

// File: rtl/idct4_stage_round_clip.sv
// Rounding right shift (floor toward -inf) followed by saturation to 16 bits.
module round_clip
  import idct_pkg::*;
#(
  parameter int unsigned SHIFT = 7
) (
  input  acc_t    y,
  output sample_t res
);

  typedef logic signed [ACC_W:0] wide_t;

  localparam wide_t RND  = wide_t'(1) << (SHIFT - 1);
  localparam wide_t MAXV = wide_t'(32767);
  localparam wide_t MINV = -wide_t'(32768);

  wide_t ext;
  wide_t sh;

  // One extra bit keeps the rounding add from overflowing at the extreme sums.
  always_comb begin
    ext = wide_t'(y) + RND;
    sh  = ext >>> SHIFT;
    if (sh > MAXV)
      res = sample_t'(32767);
    else if (sh < MINV)
      res = sample_t'(-32768);
    else
      res = sh[OUT_W-1:0];
  end

endmodule

// File: rtl/idct4_stage.sv
// Two-register 4-point inverse DCT row stage with valid/ready on both sides
// and a row counter marking the last row of each 4x4 block.
module idct4_stage
  import idct_pkg::*;
#(
  parameter int unsigned SHIFT = 7
) (
  input  logic    clk,
  input  logic    rst,
  input  coef_t   IN_tr [4],
  input  logic    in_valid,
  output logic    in_ready,
  output sample_t OUT [4],
  output logic    out_valid,
  input  logic    out_ready,
  output logic    out_last
);

  logic       s1_v, s2_v;
  logic [1:0] row_cnt, row1, row2;
  acc_t       e0, e1, o0, o1;
  acc_t       y [4];
  sample_t    rc [4];
  logic       adv, accept;

  // S2 frees up whenever it is empty or being drained; S1 moves with it.
  assign adv      = !s2_v || out_ready;
  assign in_ready = !s1_v || adv;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      row_cnt <= '0;
      row1    <= '0;
      e0      <= '0;
      e1      <= '0;
      o0      <= '0;
      o1      <= '0;
    end else begin
      if (adv || !s1_v) begin
        s1_v <= accept;
        if (accept) begin
          e0   <= C64 * (acc_t'(IN_tr[0]) + acc_t'(IN_tr[2]));
          e1   <= C64 * (acc_t'(IN_tr[0]) - acc_t'(IN_tr[2]));
          o0   <= C83 * acc_t'(IN_tr[1]) + C36 * acc_t'(IN_tr[3]);
          o1   <= C36 * acc_t'(IN_tr[1]) - C83 * acc_t'(IN_tr[3]);
          row1 <= row_cnt;
        end
      end
      if (accept)
        row_cnt <= row_cnt + 2'd1;
    end
  end

  always_comb begin
    y[0] = e0 + o0;
    y[1] = e1 + o1;
    y[2] = e1 - o1;
    y[3] = e0 - o0;
  end

  for (genvar k = 0; k < 4; k++) begin : g_rc
    round_clip #(.SHIFT(SHIFT)) u_rc (
      .y   (y[k]),
      .res (rc[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v <= 1'b0;
      row2 <= '0;
      for (int unsigned k = 0; k < 4; k++)
        OUT[k] <= '0;
    end else if (adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        row2 <= row1;
        for (int unsigned k = 0; k < 4; k++)
          OUT[k] <= rc[k];
      end
    end
  end

  assign out_valid = s2_v;
  assign out_last  = s2_v && (row2 == 2'd3);

endmodule
